// File: rtl/lcd_rgb_rx.sv
// rtl/lcd_rgb_rx.sv - parallel RGB565 LCD receiver: pixel coordinates, frame geometry, lock and checksum
// Two-stage input sampling; all frame bookkeeping happens at the VSYNC assertion edge.
module lcd_rgb_rx #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        PIXEL_CLK,
  input  logic        RESET,
  input  logic        LCD_HSYNC,
  input  logic        LCD_VSYNC,
  input  logic        LCD_DEN,
  input  logic [4:0]  LCD_R,
  input  logic [5:0]  LCD_G,
  input  logic [4:0]  LCD_B,
  output logic        PIX_VALID,
  output logic [10:0] PIX_X,
  output logic [10:0] PIX_Y,
  output logic [15:0] PIX_RGB,
  output logic        FRAME_START,
  output logic        FRAME_DONE,
  output logic [10:0] ACT_W,
  output logic [10:0] ACT_H,
  output logic [23:0] CHECKSUM,
  output logic        LOCKED,
  output logic [7:0]  ERR_COUNT
);
  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;
  localparam logic [4:0] LOCK_M = 5'(LOCK_FRAMES - 1);

  logic        hs1_q, vs1_q, den1_q, hs2_q, vs2_q, den2_q;
  logic [15:0] rgb1_q;
  state_t      state_q, state_d;
  logic [10:0] run_q, run_d, y_q, y_d, wf_q, wf_d;
  logic        have_w_q, have_w_d, bad_q, bad_d;
  logic [23:0] acc_q, acc_d;
  logic [3:0]  m_q, m_d;
  logic [10:0] ref_w_q, ref_w_d, ref_h_q, ref_h_d;
  logic        ref_ok_q, ref_ok_d;
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_rgb_q, pix_rgb_d;
  logic        fstart_q, fstart_d, fdone_q, fdone_d;
  logic [10:0] act_w_q, act_w_d, act_h_q, act_h_d;
  logic [23:0] cks_q, cks_d;
  logic [7:0]  err_q, err_d;

  logic        vs_edge, den_rise, den_fall, hs_edge;
  logic [10:0] px, y_line, wf_line, fw;
  logic        have_line, bad_line, fbad, match;
  logic [23:0] acc_add;
  logic [4:0]  m_inc;

  function automatic logic [10:0] inc_sat11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  always_comb begin
    vs_edge     = vs1_q & ~vs2_q;
    den_rise    = den1_q & ~den2_q;
    den_fall    = ~den1_q & den2_q;
    hs_edge     = hs1_q & ~hs2_q;
    state_d     = state_q;
    run_d       = run_q;
    m_d         = m_q;
    ref_w_d     = ref_w_q;
    ref_h_d     = ref_h_q;
    ref_ok_d    = ref_ok_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_rgb_d   = pix_rgb_q;
    pix_valid_d = den1_q;
    fstart_d    = 1'b0;
    fdone_d     = 1'b0;
    act_w_d     = act_w_q;
    act_h_d     = act_h_q;
    cks_d       = cks_q;
    err_d       = err_q;

    // A line closing on the boundary sample still belongs to the old frame.
    y_line    = y_q;
    wf_line   = wf_q;
    have_line = have_w_q;
    bad_line  = bad_q;
    if (den_fall) begin
      y_line = inc_sat11(y_q);
      if (!have_w_q) begin
        wf_line   = run_q;
        have_line = 1'b1;
      end else if (run_q != wf_q) begin
        bad_line = 1'b1;
      end
    end

    px      = (den_rise | vs_edge) ? 11'd0 : run_q;
    acc_add = den1_q ? {8'd0, rgb1_q} : 24'd0;
    if (den1_q) begin
      run_d     = inc_sat11(px);
      pix_x_d   = px;
      pix_y_d   = vs_edge ? 11'd0 : y_q;
      pix_rgb_d = rgb1_q;
    end else if (hs_edge) begin
      run_d = 11'd0;
    end

    y_d      = y_line;
    wf_d     = wf_line;
    have_w_d = have_line;
    bad_d    = bad_line;
    acc_d    = acc_q + acc_add;

    fw    = have_line ? wf_line : 11'd0;
    fbad  = bad_line | ~have_line;
    match = ~fbad & ref_ok_q & (fw == ref_w_q) & (y_line == ref_h_q);
    m_inc = {1'b0, m_q} + 5'd1;

    if (vs_edge) begin
      fstart_d = 1'b1;
      y_d      = 11'd0;
      wf_d     = 11'd0;
      have_w_d = 1'b0;
      bad_d    = 1'b0;
      acc_d    = acc_add;
      if (state_q == ST_SEARCH) begin
        state_d = ST_MEASURE;
        m_d     = 4'd0;
      end else begin
        fdone_d = 1'b1;
        act_w_d = fw;
        act_h_d = y_line;
        cks_d   = acc_q;
        if (match) begin
          if (state_q == ST_MEASURE) begin
            m_d = m_inc[3:0];
            if (m_inc >= LOCK_M) state_d = ST_LOCKED;
          end
        end else begin
          // In LOCKED the reference is always valid, so any miss counts as an error.
          ref_w_d  = fw;
          ref_h_d  = y_line;
          ref_ok_d = ~fbad;
          m_d      = 4'd0;
          state_d  = ST_MEASURE;
          if (ref_ok_q | fbad) err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      {hs1_q, vs1_q, den1_q, hs2_q, vs2_q, den2_q} <= '0;
      rgb1_q      <= '0;
      state_q     <= ST_SEARCH;
      run_q       <= '0;
      y_q         <= '0;
      wf_q        <= '0;
      have_w_q    <= 1'b0;
      bad_q       <= 1'b0;
      acc_q       <= '0;
      m_q         <= '0;
      ref_w_q     <= '0;
      ref_h_q     <= '0;
      ref_ok_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rgb_q   <= '0;
      fstart_q    <= 1'b0;
      fdone_q     <= 1'b0;
      act_w_q     <= '0;
      act_h_q     <= '0;
      cks_q       <= '0;
      err_q       <= '0;
    end else begin
      // Syncs are normalised so that 1 always means asserted.
      hs1_q       <= LCD_HSYNC ^ SYNC_ACTIVE_LOW;
      vs1_q       <= LCD_VSYNC ^ SYNC_ACTIVE_LOW;
      den1_q      <= LCD_DEN;
      rgb1_q      <= {LCD_R, LCD_G, LCD_B};
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      den2_q      <= den1_q;
      state_q     <= state_d;
      run_q       <= run_d;
      y_q         <= y_d;
      wf_q        <= wf_d;
      have_w_q    <= have_w_d;
      bad_q       <= bad_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      ref_w_q     <= ref_w_d;
      ref_h_q     <= ref_h_d;
      ref_ok_q    <= ref_ok_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_rgb_q   <= pix_rgb_d;
      fstart_q    <= fstart_d;
      fdone_q     <= fdone_d;
      act_w_q     <= act_w_d;
      act_h_q     <= act_h_d;
      cks_q       <= cks_d;
      err_q       <= err_d;
    end
  end

  assign PIX_VALID   = pix_valid_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign PIX_RGB     = pix_rgb_q;
  assign FRAME_START = fstart_q;
  assign FRAME_DONE  = fdone_q;
  assign ACT_W       = act_w_q;
  assign ACT_H       = act_h_q;
  assign CHECKSUM    = cks_q;
  assign LOCKED      = (state_q == ST_LOCKED);
  assign ERR_COUNT   = err_q;
endmodule

// File: tb/tb_lcd_rgb_rx.sv
// tb/tb_lcd_rgb_rx.sv - scoreboard bench for lcd_rgb_rx
// Stimulus pushes expected pixels/frames into queues; monitors pop on PIX_VALID / FRAME_DONE.
module tb_lcd_rgb_rx;
  typedef struct { int x; int y; int v; int c; } pix_t;
  typedef struct { int w; int h; int cks; int lk; int err; } frm_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hs, vs, den;
  logic [4:0] r, b;
  logic [5:0] g;
  logic pv, fs, fd, lk, pv2, fs2, fd2, lk2;
  logic [10:0] px, py, aw, ah, px2, py2, aw2, ah2;
  logic [15:0] prgb, prgb2;
  logic [23:0] cks, cks2;
  logic [7:0] ec, ec2;

  lcd_rgb_rx #(.SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)) dut (
    .PIXEL_CLK(clk), .RESET(rst), .LCD_HSYNC(hs), .LCD_VSYNC(vs), .LCD_DEN(den),
    .LCD_R(r), .LCD_G(g), .LCD_B(b), .PIX_VALID(pv), .PIX_X(px), .PIX_Y(py),
    .PIX_RGB(prgb), .FRAME_START(fs), .FRAME_DONE(fd), .ACT_W(aw), .ACT_H(ah),
    .CHECKSUM(cks), .LOCKED(lk), .ERR_COUNT(ec));

  lcd_rgb_rx #(.SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(2)) dut2 (
    .PIXEL_CLK(clk), .RESET(rst), .LCD_HSYNC(~hs), .LCD_VSYNC(~vs), .LCD_DEN(den),
    .LCD_R(r), .LCD_G(g), .LCD_B(b), .PIX_VALID(pv2), .PIX_X(px2), .PIX_Y(py2),
    .PIX_RGB(prgb2), .FRAME_START(fs2), .FRAME_DONE(fd2), .ACT_W(aw2), .ACT_H(ah2),
    .CHECKSUM(cks2), .LOCKED(lk2), .ERR_COUNT(ec2));

  int checks = 0, errors = 0, cyc = 0, n_vs = 0, n_fs = 0, n_fs2 = 0;
  bit rst_seen = 1'b0, mon_en = 1'b0;
  pix_t pq[$];
  frm_t fq1[$], fq2[$];
  int vq[$];
  logic [54:0] prev;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input bit h, input bit d, input logic [15:0] rgb);
    vs = v ? 1'b0 : 1'b1;
    hs = h ? 1'b0 : 1'b1;
    den = d;
    {r, g, b} = rgb;
    @(negedge clk);
  endtask

  task automatic send_vs();
    vq.push_back(cyc);
    n_vs++;
    drive(1, 0, 0, 16'h0); drive(1, 0, 0, 16'h0);
    drive(0, 0, 0, 16'h0); drive(0, 0, 0, 16'h0);
  endtask

  function automatic logic [15:0] pixv(input int pat, input int x, input int y);
    case (pat)
      0: return 16'hFFFF;
      1: return 16'(x);
      default: return 16'(x * 37 + y * 1021 + 5);
    endcase
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, pv, 0);
    chk({tag, "_act_w"}, aw, 0);
    chk({tag, "_act_h"}, ah, 0);
    chk({tag, "_cks"}, cks, 0);
    chk({tag, "_locked"}, lk, 0);
    chk({tag, "_err"}, ec, 0);
    chk({tag, "_fdone"}, fd, 0);
    chk({tag, "_locked2"}, lk2, 0);
  endtask

  task automatic send_frame(input int w, input int h, input int short_l, input int pat,
                            input int rst_row, input bit merge, input bit expe,
                            input int elk, input int eerr);
    int ey, acc, lw;
    logic [15:0] v;
    pix_t p;
    frm_t f;
    ey = 0;
    acc = 0;
    if (!merge) send_vs();
    for (int l = 0; l < h; l++) begin
      if (l == rst_row) begin
        rst = 1'b1;
        drive(0, 0, 0, 16'h0);
        rst = 1'b0;
        check_zero("mid_reset");
        ey = 0;
        repeat (3) drive(0, 0, 0, 16'h0);
      end
      if (!(merge && l == 0)) begin
        drive(0, 1, 0, 16'h0); drive(0, 0, 0, 16'h0); drive(0, 0, 0, 16'h0);
      end
      lw = (l == short_l) ? w - 1 : w;
      for (int x = 0; x < lw; x++) begin
        v = pixv(pat, x, ey);
        if (merge && l == 0 && x == 0) begin
          vq.push_back(cyc);
          n_vs++;
        end
        p.x = x; p.y = ey; p.v = int'(v); p.c = cyc;
        pq.push_back(p);
        acc = (acc + int'(v)) & 32'h00FF_FFFF;
        drive(merge && l == 0 && x < 2, 0, 1, v);
      end
      repeat (3) drive(0, 0, 0, 16'h0);
      if (lw > 0) ey++;
    end
    if (expe) begin
      f.w = (w == 0) ? 0 : w;
      f.h = (w == 0) ? 0 : h;
      f.cks = acc; f.lk = elk; f.err = eerr;
      fq1.push_back(f);
      fq2.push_back(f);
    end
  endtask

  always @(negedge clk) begin
    pix_t p;
    frm_t f;
    if (mon_en) begin
      if (pv) begin
        if (pq.size() == 0) chk("pix_unexpected", 1, 0);
        else begin
          p = pq.pop_front();
          chk("pix_x", px, p.x);
          chk("pix_y", py, p.y);
          chk("pix_rgb", prgb, p.v);
          chk("pix_latency", cyc - p.c, 2);
        end
      end
      if (fs) begin
        n_fs++;
        if (vq.size() == 0) chk("fstart_unexpected", 1, 0);
        else chk("fstart_latency", cyc - vq.pop_front(), 2);
      end
      if (fs2) n_fs2++;
      if (fd) begin
        chk("fdone_with_fstart", fs, 1);
        if (fq1.size() == 0) chk("fdone_unexpected", 1, 0);
        else begin
          f = fq1.pop_front();
          chk("act_w", aw, f.w);
          chk("act_h", ah, f.h);
          chk("checksum", cks, f.cks);
          chk("locked", lk, f.lk);
          chk("err_count", ec, f.err);
        end
      end else if (!rst_seen) begin
        chk("hold_between_frames", {aw, ah, cks, lk, ec}, prev);
      end
      if (fd2) begin
        if (fq2.size() == 0) chk("fdone2_unexpected", 1, 0);
        else begin
          f = fq2.pop_front();
          chk("act_w2", aw2, f.w);
          chk("act_h2", ah2, f.h);
          chk("checksum2", cks2, f.cks);
          chk("locked2", lk2, f.lk);
          chk("err_count2", ec2, f.err);
        end
      end
    end
    prev = {aw, ah, cks, lk, ec};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, ex;
    rst = 1'b1;
    hs = 1'b1; vs = 1'b1; den = 1'b0; {r, g, b} = 16'h0;
    repeat (3) drive(0, 0, 0, 16'h0);
    check_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) drive(0, 0, 0, 16'h0);

    send_frame(480, 3, -1, 1, -1, 0, 1, 0, 0);
    send_frame(8, 4, -1, 0, -1, 0, 1, 0, 1);
    send_frame(8, 4, -1, 0, -1, 0, 1, 1, 1);
    send_frame(8, 4, -1, 2, -1, 0, 1, 1, 1);
    send_frame(8, 4, 2, 2, -1, 0, 1, 0, 2);
    send_frame(8, 4, -1, 0, -1, 0, 1, 0, 2);
    send_frame(8, 4, -1, 2, -1, 1, 1, 1, 2);
    send_frame(12, 6, -1, 2, -1, 0, 1, 0, 3);
    send_frame(12, 6, -1, 2, -1, 0, 1, 1, 3);
    send_frame(12, 6, -1, 2, 3, 0, 0, 0, 0);
    send_frame(12, 6, -1, 2, -1, 0, 1, 0, 0);
    send_frame(12, 6, -1, 2, -1, 0, 1, 1, 0);
    send_frame(0, 2, -1, 0, -1, 0, 1, 0, 1);
    e = 1;
    for (int i = 0; i < 300; i++) begin
      ex = (i == 0) ? e : ((e + 1 > 255) ? 255 : e + 1);
      send_frame((i % 2 == 0) ? 2 : 3, 1, -1, 2, -1, 0, 1, 0, ex);
      e = ex;
    end
    send_vs();
    repeat (8) drive(0, 0, 0, 16'h0);

    chk("pixels_left", pq.size(), 0);
    chk("frames_left", fq1.size(), 0);
    chk("frames2_left", fq2.size(), 0);
    chk("fstart_count", n_fs, n_vs);
    chk("fstart2_count", n_fs2, n_vs);
    chk("final_err_sat", ec, 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
